// File: rtl/i2c_pkg.sv
// Shared encodings and timing helpers for the i2c_master arbiter.
// Stop-phase wait is derived from the system clock and bus tick rates.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        XFER,
        STOP,
        ERR
    } arb_state_t;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    function automatic int tick_div(input int f_clk, input int f_bus);
        return f_clk / f_bus;
    endfunction

    // Covers the master's end + finish phases after m_ena drops.
    function automatic int stop_wait(input int f_clk, input int f_bus);
        return 4 * tick_div(f_clk, f_bus) + 8;
    endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// Host-side descriptor/data handshake plus the i2c_master control bus.
// master = arbiter view, slave = requesters + i2c_master view.
interface i2c_arbiter_if import i2c_pkg::*; #(
    parameter int N_REQ = 2,
    parameter int LEN_W = 4
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_rd_wrt;
    logic [ADDR_W*N_REQ-1:0] req_addr;
    logic [LEN_W*N_REQ-1:0]  req_len;
    logic [DATA_W*N_REQ-1:0] wr_data;
    logic [N_REQ-1:0]        wr_ready;
    logic [DATA_W-1:0]       rd_data;
    logic [N_REQ-1:0]        rd_valid;
    logic [N_REQ-1:0]        done;
    logic                    done_err;
    logic                    m_ena;
    logic                    m_rd_wrt;
    logic [ADDR_W-1:0]       m_addr;
    logic [DATA_W-1:0]       m_data_wrt;
    logic [DATA_W-1:0]       m_data_rd;
    logic                    m_busy;
    logic                    m_err;
    logic                    m_rst;

    modport master (
        input  req_valid, req_rd_wrt, req_addr, req_len, wr_data,
        input  m_data_rd, m_busy, m_err,
        output req_ready, wr_ready, rd_data, rd_valid, done, done_err,
        output m_ena, m_rd_wrt, m_addr, m_data_wrt, m_rst
    );

    modport slave (
        output req_valid, req_rd_wrt, req_addr, req_len, wr_data,
        output m_data_rd, m_busy, m_err,
        input  req_ready, wr_ready, rd_data, rd_valid, done, done_err,
        input  m_ena, m_rd_wrt, m_addr, m_data_wrt, m_rst
    );

endinterface

// File: rtl/i2c_rr_arb.sv
// Combinational N-way grant, one-hot plus index; round-robin from ptr by default,
// fixed lowest-index priority when I2C_ARB_PRIO_EN is defined.
module i2c_rr_arb import i2c_pkg::*; #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx
);

`ifdef I2C_ARB_PRIO_EN
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_oh    = '0;
                gnt_oh[i] = 1'b1;
                gnt_idx   = IW'(i);
            end
        end
    end
`else
    logic found;
    int   j;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                gnt_oh[j] = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_master among N_REQ requesters, sequencing multi-byte transfers byte by byte.
// Recovers the master from its error state with a 2-cycle m_rst pulse; watchdog on every handshake edge.
module i2c_arbiter import i2c_pkg::*; #(
    parameter int N_REQ       = 2,
    parameter int LEN_W       = 4,
    parameter int F_CLK       = 50_000_000,
    parameter int F_BUS       = 400_000,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic          clk,
    input  logic          reset,
    i2c_arbiter_if.master bus
);

    localparam int IW     = $clog2(N_REQ);
    localparam int SW_CYC = stop_wait(F_CLK, F_BUS);
    localparam int SCW    = $clog2(SW_CYC + 1);
    localparam int WDW    = $clog2(TIMEOUT_CYC + 1);

    arb_state_t       state;
    logic [IW-1:0]    owner, rr_ptr, gnt_idx, nxt_ptr;
    logic [N_REQ-1:0] own_oh, gnt_oh;
    logic [LEN_W-1:0] cnt;
    logic [WDW-1:0]   wd;
    logic [SCW-1:0]   stop_cnt;
    logic             rst_cnt, busy_q;
    logic             busy_rise, busy_fall, busy_edge, timeout, to_err;

    i2c_rr_arb #(.N(N_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    assign busy_rise = bus.m_busy & ~busy_q;
    assign busy_fall = ~bus.m_busy & busy_q;
    assign busy_edge = busy_rise | busy_fall;
    assign timeout   = ~busy_edge && (wd == WDW'(TIMEOUT_CYC - 1)) &&
                       (state == ISSUE || state == XFER);
    assign to_err    = timeout ||
                       (bus.m_err && (state == ISSUE || state == XFER || state == STOP));
    assign nxt_ptr   = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= '0;
            own_oh         <= '0;
            rr_ptr         <= '0;
            cnt            <= '0;
            wd             <= '0;
            stop_cnt       <= '0;
            rst_cnt        <= 1'b0;
            busy_q         <= 1'b0;
            bus.req_ready  <= '0;
            bus.wr_ready   <= '0;
            bus.rd_data    <= '0;
            bus.rd_valid   <= '0;
            bus.done       <= '0;
            bus.done_err   <= 1'b0;
            bus.m_ena      <= 1'b0;
            bus.m_rd_wrt   <= 1'b0;
            bus.m_addr     <= '0;
            bus.m_data_wrt <= '0;
            bus.m_rst      <= 1'b0;
        end else begin
            bus.req_ready <= '0;
            bus.wr_ready  <= '0;
            bus.rd_valid  <= '0;
            bus.done      <= '0;
            bus.done_err  <= 1'b0;
            busy_q        <= bus.m_busy;
            wd            <= busy_edge ? '0 : wd + 1'b1;

            if (to_err) begin
                // Abandon remaining bytes; the master is reset before reporting.
                state     <= ERR;
                bus.m_ena <= 1'b0;
                bus.m_rst <= 1'b1;
                rst_cnt   <= 1'b0;
                wd        <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (|bus.req_valid) begin
                            owner         <= gnt_idx;
                            own_oh        <= gnt_oh;
                            bus.req_ready <= gnt_oh;
                            bus.m_addr    <= bus.req_addr[ADDR_W*gnt_idx +: ADDR_W];
                            bus.m_rd_wrt  <= bus.req_rd_wrt[gnt_idx];
                            cnt           <= bus.req_len[LEN_W*gnt_idx +: LEN_W];
                            bus.m_ena     <= 1'b1;
                            if (!bus.req_rd_wrt[gnt_idx]) begin
                                bus.m_data_wrt <= bus.wr_data[DATA_W*gnt_idx +: DATA_W];
                                bus.wr_ready   <= gnt_oh;
                            end
                            state <= ISSUE;
                            wd    <= '0;
                        end
                    end
                    ISSUE: begin
                        if (busy_rise) begin
                            state <= XFER;
                            wd    <= '0;
                        end
                    end
                    XFER: begin
                        if (busy_fall) begin
                            if (bus.m_rd_wrt) begin
                                bus.rd_data  <= bus.m_data_rd;
                                bus.rd_valid <= own_oh;
                            end
                            if (cnt != '0) begin
                                cnt <= cnt - 1'b1;
                                if (!bus.m_rd_wrt) begin
                                    bus.m_data_wrt <= bus.wr_data[DATA_W*owner +: DATA_W];
                                    bus.wr_ready   <= own_oh;
                                end
                            end else begin
                                // Dropping ena before the ack tick makes the master stop (NACK on reads).
                                bus.m_ena <= 1'b0;
                                stop_cnt  <= '0;
                                state     <= STOP;
                                wd        <= '0;
                            end
                        end
                    end
                    STOP: begin
                        if (stop_cnt == SCW'(SW_CYC - 1)) begin
                            bus.done <= own_oh;
                            rr_ptr   <= nxt_ptr;
                            state    <= IDLE;
                            wd       <= '0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    ERR: begin
                        if (rst_cnt) begin
                            bus.m_rst    <= 1'b0;
                            bus.done     <= own_oh;
                            bus.done_err <= 1'b1;
                            rr_ptr       <= nxt_ptr;
                            state        <= IDLE;
                            wd           <= '0;
                        end else begin
                            rst_cnt <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter; the i2c_master is emulated at the busy/err handshake level.
module tb_i2c_arbiter;
    import i2c_pkg::*;

    localparam int N_REQ       = 2;
    localparam int LEN_W       = 4;
    localparam int F_CLK       = 1_000_000;
    localparam int F_BUS       = 250_000;
    localparam int TIMEOUT_CYC = 200;
    localparam int SW          = 24;   // 4*(1e6/250e3)+8

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_arbiter_if #(.N_REQ(N_REQ), .LEN_W(LEN_W)) bif ();

    i2c_arbiter #(
        .N_REQ(N_REQ), .LEN_W(LEN_W), .F_CLK(F_CLK), .F_BUS(F_BUS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int         checks = 0;
    int         errors = 0;
    int         wr_cnt0 = 0;
    int         wr_cnt1 = 0;
    logic [7:0] rd_log[$];
    logic [7:0] sent[$];

    always @(negedge clk) begin
        if (bif.wr_ready[0]) wr_cnt0++;
        if (bif.wr_ready[1]) wr_cnt1++;
        if (|bif.rd_valid) rd_log.push_back(bif.rd_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] rd_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] sent_at(input int i);
        return (i < sent.size()) ? sent[i] : 8'hxx;
    endfunction

    task automatic set_req(input int i, input logic rw, input logic [6:0] a,
                           input logic [3:0] l, input logic [7:0] d);
        bif.req_rd_wrt[i]     = rw;
        bif.req_addr[7*i +: 7] = a;
        bif.req_len[4*i +: 4]  = l;
        bif.wr_data[8*i +: 8]  = d;
    endtask

    task automatic wait_grant(output logic [1:0] g);
        g = '0;
        for (int i = 0; i < 50 && g == 2'b00; i++) begin
            cyc(1);
            g = bif.req_ready;
        end
    endtask

    // One master byte: busy rises, data_wrt is sampled, busy falls with read data.
    task automatic do_byte(input logic [7:0] rd_byte);
        cyc(2);
        bif.m_busy = 1'b1;
        cyc(1);
        sent.push_back(bif.m_data_wrt);
        cyc(4);
        bif.m_data_rd = rd_byte;
        bif.m_busy    = 1'b0;
        cyc(1);
    endtask

    task automatic finish_stop(input string tag, input logic [1:0] exp);
        cyc(SW - 1);
        chk({tag, "_done_early"}, bif.done, 2'b00);
        cyc(1);
        chk({tag, "_done"}, bif.done, exp);
        chk({tag, "_done_err"}, bif.done_err, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] g;
        logic [1:0] exp_g;
        int         n;
        int         w0;

        reset          = 1'b1;
        bif.req_valid  = '0;
        bif.req_rd_wrt = '0;
        bif.req_addr   = '0;
        bif.req_len    = '0;
        bif.wr_data    = '0;
        bif.m_data_rd  = '0;
        bif.m_busy     = 1'b0;
        bif.m_err      = 1'b0;
        cyc(2);
        chk("rst_ctrl", {bif.m_ena, bif.m_rst, bif.done, bif.done_err,
                         bif.req_ready, bif.wr_ready, bif.rd_valid}, 0);
        chk("rst_bus", {bif.m_addr, bif.m_rd_wrt, bif.m_data_wrt, bif.rd_data}, 0);
        reset = 1'b0;
        cyc(2);

        // Write 0x50, three bytes A5 3C FF
        set_req(0, 1'b0, 7'h50, 4'd2, 8'hA5);
        bif.req_valid = 2'b01;
        wait_grant(g);
        chk("w_grant", g, 2'b01);
        bif.req_valid = 2'b00;
        bif.wr_data[7:0] = 8'h3C;
        chk("w_addr_byte", {bif.m_addr, bif.m_rd_wrt}, 8'hA0);
        sent.delete();
        do_byte(8'h00);
        chk("w_ena_hold", bif.m_ena, 1'b1);
        bif.wr_data[7:0] = 8'hFF;
        do_byte(8'h00);
        bif.wr_data[7:0] = 8'h00;
        do_byte(8'h00);
        chk("w_ena_drop", bif.m_ena, 1'b0);
        chk("w_addr_stable", bif.m_addr, 7'h50);
        finish_stop("w", 2'b01);
        chk("w_wr_ready_cnt", wr_cnt0, 3);
        chk("w_byte0", sent_at(0), 8'hA5);
        chk("w_byte1", sent_at(1), 8'h3C);
        chk("w_byte2", sent_at(2), 8'hFF);

        // Read 0x68, two bytes
        set_req(1, 1'b1, 7'h68, 4'd1, 8'h00);
        bif.req_valid = 2'b10;
        wait_grant(g);
        chk("r_grant", g, 2'b10);
        bif.req_valid = 2'b00;
        chk("r_addr_byte", {bif.m_addr, bif.m_rd_wrt}, 8'hD1);
        rd_log.delete();
        do_byte(8'h12);
        chk("r_ena_ack", bif.m_ena, 1'b1);
        do_byte(8'h34);
        chk("r_ena_nack", bif.m_ena, 1'b0);
        finish_stop("r", 2'b10);
        chk("r_cnt", rd_log.size(), 2);
        chk("r_data0", rd_at(0), 8'h12);
        chk("r_data1", rd_at(1), 8'h34);
        chk("r_no_wr_ready", wr_cnt1, 0);

        // Both requesters continuously valid
        set_req(0, 1'b0, 7'h10, 4'd0, 8'h11);
        set_req(1, 1'b0, 7'h11, 4'd0, 8'h22);
        bif.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef I2C_ARB_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            wait_grant(g);
            chk($sformatf("arb_grant%0d", k), g, exp_g);
            sent.delete();
            do_byte(8'h00);
            chk($sformatf("arb_data%0d", k), sent_at(0), (exp_g == 2'b01) ? 8'h11 : 8'h22);
            chk($sformatf("arb_addr%0d", k), bif.m_addr, (exp_g == 2'b01) ? 7'h10 : 7'h11);
            finish_stop($sformatf("arb%0d", k), exp_g);
        end
        bif.req_valid = 2'b00;
        cyc(3);

        // Address NACK -> master error, recovery pulse, then a clean transfer
        w0 = wr_cnt0;
        set_req(0, 1'b0, 7'h22, 4'd0, 8'h77);
        bif.req_valid = 2'b01;
        wait_grant(g);
        chk("nack_grant", g, 2'b01);
        bif.req_valid = 2'b00;
        cyc(2);
        bif.m_busy = 1'b1;
        cyc(3);
        bif.m_err = 1'b1;
        cyc(1);
        chk("nack_rst1", bif.m_rst, 1'b1);
        chk("nack_ena", bif.m_ena, 1'b0);
        bif.m_err  = 1'b0;
        bif.m_busy = 1'b0;
        cyc(1);
        chk("nack_rst2", bif.m_rst, 1'b1);
        chk("nack_done_early", bif.done, 2'b00);
        cyc(1);
        chk("nack_rst_end", bif.m_rst, 1'b0);
        chk("nack_done", bif.done, 2'b01);
        chk("nack_done_err", bif.done_err, 1'b1);
        cyc(1);
        chk("nack_wr_ready_cnt", wr_cnt0 - w0, 1);
        set_req(1, 1'b0, 7'h2A, 4'd0, 8'h5C);
        bif.req_valid = 2'b10;
        wait_grant(g);
        chk("post_nack_grant", g, 2'b10);
        bif.req_valid = 2'b00;
        sent.delete();
        do_byte(8'h00);
        chk("post_nack_data", sent_at(0), 8'h5C);
        finish_stop("post_nack", 2'b10);

        // Busy stuck high -> watchdog
        set_req(1, 1'b0, 7'h3B, 4'd3, 8'h01);
        bif.req_valid = 2'b10;
        wait_grant(g);
        chk("to_grant", g, 2'b10);
        bif.req_valid = 2'b00;
        cyc(2);
        bif.m_busy = 1'b1;
        cyc(1);
        n = 0;
        for (int i = 1; i <= 400 && n == 0; i++) begin
            cyc(1);
            if (bif.m_rst) n = i;
        end
        chk("to_cycles", n, TIMEOUT_CYC);
        cyc(1);
        chk("to_rst2", bif.m_rst, 1'b1);
        cyc(1);
        chk("to_done", bif.done, 2'b10);
        chk("to_done_err", bif.done_err, 1'b1);
        bif.m_busy = 1'b0;
        cyc(2);

        // Reset in the middle of a transfer
        set_req(0, 1'b0, 7'h45, 4'd2, 8'h99);
        bif.req_valid = 2'b01;
        wait_grant(g);
        bif.req_valid = 2'b00;
        cyc(2);
        bif.m_busy = 1'b1;
        cyc(2);
        chk("mid_ena_pre", bif.m_ena, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ctrl", {bif.m_ena, bif.m_rst, bif.done, bif.done_err,
                             bif.req_ready, bif.wr_ready, bif.rd_valid}, 0);
        chk("mid_rst_bus", {bif.m_addr, bif.m_rd_wrt, bif.m_data_wrt, bif.rd_data}, 0);
        bif.m_busy = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        set_req(0, 1'b1, 7'h33, 4'd0, 8'h00);
        bif.req_valid = 2'b01;
        wait_grant(g);
        chk("post_rst_grant", g, 2'b01);
        bif.req_valid = 2'b00;
        rd_log.delete();
        do_byte(8'h5A);
        chk("post_rst_ena", bif.m_ena, 1'b0);
        finish_stop("post_rst", 2'b01);
        chk("post_rst_rd", rd_at(0), 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
